// File: rtl/oam_line_scanner_pkg.sv
// Shared video types for the OAM line scanner: list capacity, Y offset,
// sprite heights, the selected-slot record and the scanner state encoding.
package oam_line_scanner_pkg;

    localparam int OAM_MAX_PER_LINE = 10;
    localparam int OAM_Y_OFFSET     = 16;
    localparam int OAM_H_SHORT      = 8;
    localparam int OAM_H_TALL       = 16;

    typedef struct packed {
        logic [5:0] index;
        logic [7:0] XPosition;
    } SpriteSlot;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/oam_line_hit.sv
// Y-range test for one OAM entry against the current LCD line. Everything is
// widened to 9 bits so ly+16 and oam_y+h never wrap.
module oam_line_hit
    import oam_line_scanner_pkg::*;
(
    input  logic [7:0] ly,
    input  logic [7:0] oam_y,
    input  logic       tall,
    output logic       hit
);

    logic [8:0] line_pos;
    logic [8:0] y_top;
    logic [8:0] y_end;

    // Sprite covers screen rows [oam_y-16, oam_y-16+h); compare in offset space.
    always_comb begin
        line_pos = {1'b0, ly} + 9'(OAM_Y_OFFSET);
        y_top    = {1'b0, oam_y};
        y_end    = y_top + (tall ? 9'(OAM_H_TALL) : 9'(OAM_H_SHORT));
        hit      = (line_pos >= y_top) && (line_pos < y_end);
    end

endmodule

// File: rtl/oam_line_scanner.sv
// OAM line scanner: walks all OAM entries once per start, selects the sprites
// that overlap the latched line and records up to MAX_PER_LINE of them.
// Build option OAM_XSORT_EN keeps the list sorted by X (stable); without it the
// list is in OAM index order. Timing is identical in both builds.
module oam_line_scanner
    import oam_line_scanner_pkg::*;
#(
    parameter  int NUM_SPRITES  = 40,
    parameter  int MAX_PER_LINE = OAM_MAX_PER_LINE,
    localparam int IDX_W        = $clog2(NUM_SPRITES),
    localparam int CNT_W        = $clog2(MAX_PER_LINE + 1)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [7:0]                             ly,
    input  logic                                   tall,
    output logic [IDX_W-1:0]                       oam_idx,
    input  logic [7:0]                             oam_y,
    input  logic [7:0]                             oam_x,
    output logic                                   busy,
    output logic                                   done,
    output logic [CNT_W-1:0]                       sel_count,
    output logic [MAX_PER_LINE-1:0][IDX_W-1:0]     sel_idx,
    output logic [MAX_PER_LINE-1:0][7:0]           sel_x
);

    scan_state_t state, state_next;

    logic                                 accept;
    logic                                 last_addr;
    logic [7:0]                           ly_q;
    logic                                 tall_q;
    logic                                 vld_p1;
    logic [IDX_W-1:0]                     idx_p1;
    logic                                 hit;
    logic                                 take;
    logic [CNT_W-1:0]                     pos;
    logic [MAX_PER_LINE-1:0][IDX_W-1:0]   idx_next;
    logic [MAX_PER_LINE-1:0][7:0]         x_next;

    assign accept    = (state == ST_IDLE) && start;
    assign last_addr = (oam_idx == IDX_W'(NUM_SPRITES - 1));
    assign take      = vld_p1 && hit && (sel_count < CNT_W'(MAX_PER_LINE));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SCAN;
            ST_SCAN: begin
                busy = 1'b1;
                if (last_addr) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Address counter and evaluation-valid flag (stage 0 -> stage 1).
    always_ff @(posedge clk) begin
        if (reset) begin
            oam_idx <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= (state == ST_SCAN);
            if (state == ST_SCAN) oam_idx <= last_addr ? '0 : oam_idx + 1'b1;
        end
    end

    // Line parameters captured at start; entry index follows the read latency.
    always_ff @(posedge clk) begin
        idx_p1 <= oam_idx;
        if (accept) begin
            ly_q   <= ly;
            tall_q <= tall;
        end
    end

    oam_line_hit u_hit (
        .ly    (ly_q),
        .oam_y (oam_y),
        .tall  (tall_q),
        .hit   (hit)
    );

    // Insertion slot: after every entry with X <= new X keeps the sort stable.
    always_comb begin
`ifdef OAM_XSORT_EN
        pos = '0;
        for (int j = 0; j < MAX_PER_LINE; j++) begin
            if ((CNT_W'(j) < sel_count) && (sel_x[j] <= oam_x)) pos = pos + 1'b1;
        end
`else
        pos = sel_count;
`endif
    end

    // List after inserting the current entry at pos, shifting the tail up.
    always_comb begin
        idx_next = sel_idx;
        x_next   = sel_x;
        for (int j = 0; j < MAX_PER_LINE; j++) begin
            if (CNT_W'(j) == pos) begin
                idx_next[j] = idx_p1;
                x_next[j]   = oam_x;
            end else if (CNT_W'(j) > pos) begin
                idx_next[j] = sel_idx[(j > 0) ? j - 1 : 0];
                x_next[j]   = sel_x[(j > 0) ? j - 1 : 0];
            end
        end
    end

    // Selected-sprite list; cleared on reset and on every accepted start.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            sel_count <= '0;
            sel_idx   <= '0;
            sel_x     <= '0;
        end else if (take) begin
            sel_count <= sel_count + 1'b1;
            sel_idx   <= idx_next;
            sel_x     <= x_next;
        end
    end

endmodule

// File: tb/tb_oam_line_scanner.sv
// Bench for oam_line_scanner: table vectors, hand sequences for reset and
// start handling, and randomized scans against a list-based reference model.
// Expected list order follows the OAM_XSORT_EN build option.
module tb_oam_line_scanner;

    localparam int NS = 40;
    localparam int MP = 10;
    localparam int IW = $clog2(NS);
    localparam int CW = $clog2(MP + 1);

    logic                   clk = 1'b0;
    logic                   reset, start, tall;
    logic [7:0]             ly, oam_y, oam_x;
    logic [IW-1:0]          oam_idx;
    logic                   busy, done;
    logic [CW-1:0]          sel_count;
    logic [MP-1:0][IW-1:0]  sel_idx;
    logic [MP-1:0][7:0]     sel_x;

    oam_line_scanner #(.NUM_SPRITES(NS), .MAX_PER_LINE(MP)) dut (
        .clk(clk), .reset(reset), .start(start), .ly(ly), .tall(tall),
        .oam_idx(oam_idx), .oam_y(oam_y), .oam_x(oam_x), .busy(busy),
        .done(done), .sel_count(sel_count), .sel_idx(sel_idx), .sel_x(sel_x)
    );

    always #5 clk = ~clk;

    logic [7:0] y_mem [NS];
    logic [7:0] x_mem [NS];

    // OAM memory with one cycle of read latency.
    always @(posedge clk) begin
        oam_y <= y_mem[oam_idx];
        oam_x <= x_mem[oam_idx];
    end

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt;
    int exp_idx [MP];

    typedef struct {
        int       pat;
        int       lyv;
        bit       tallv;
        int       cnt;
        int       idx [MP];
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int pat, input int l, input bit t, input int cnt,
                       input int i0 = 0, input int i1 = 0, input int i2 = 0,
                       input int i3 = 0, input int i4 = 0, input int i5 = 0,
                       input int i6 = 0, input int i7 = 0, input int i8 = 0,
                       input int i9 = 0);
        vec_t v;
        v.pat = pat; v.lyv = l; v.tallv = t; v.cnt = cnt;
        v.idx[0] = i0; v.idx[1] = i1; v.idx[2] = i2; v.idx[3] = i3; v.idx[4] = i4;
        v.idx[5] = i5; v.idx[6] = i6; v.idx[7] = i7; v.idx[8] = i8; v.idx[9] = i9;
        tbl.push_back(v);
    endtask

    task automatic load_pattern(input int p);
        for (int k = 0; k < NS; k++) begin
            y_mem[k] = 8'd0;
            x_mem[k] = 8'(k * 5 + 1);
        end
        case (p)
            0: begin y_mem[3] = 8'd16; y_mem[7] = 8'd9; end
            1: for (int k = 0; k < NS; k++) y_mem[k] = 8'd20;
            2: y_mem[0] = 8'd16;
            3: begin
                y_mem[2] = 8'd16; y_mem[5] = 8'd16; y_mem[9] = 8'd16;
                x_mem[2] = 8'd80; x_mem[5] = 8'd8;  x_mem[9] = 8'd80;
            end
            4: y_mem[4] = 8'd250;
            default: ;
        endcase
    endtask

    // Reference: first MP hits in OAM order, then stable sort by X if enabled.
    task automatic model(input int l, input bit t);
        int lp, h, tmp;
        lp = l + 16;
        h  = t ? 16 : 8;
        exp_cnt = 0;
        for (int k = 0; k < NS; k++) begin
            if (lp >= int'(y_mem[k]) && lp < int'(y_mem[k]) + h && exp_cnt < MP) begin
                exp_idx[exp_cnt] = k;
                exp_cnt++;
            end
        end
`ifdef OAM_XSORT_EN
        for (int i = 1; i < exp_cnt; i++) begin
            for (int j = i; j > 0; j--) begin
                if (x_mem[exp_idx[j-1]] > x_mem[exp_idx[j]]) begin
                    tmp = exp_idx[j]; exp_idx[j] = exp_idx[j-1]; exp_idx[j-1] = tmp;
                end
            end
        end
`endif
    endtask

    task automatic check_list(input string tag);
        chk({tag, ".count"}, int'(sel_count), exp_cnt);
        for (int s = 0; s < exp_cnt; s++) begin
            chk($sformatf("%s.idx%0d", tag, s), int'(sel_idx[s]), exp_idx[s]);
            chk($sformatf("%s.x%0d", tag, s), int'(sel_x[s]), int'(x_mem[exp_idx[s]]));
        end
    endtask

    // Issue one start and follow the scan; cycle n is the cycle after the n-th edge.
    task automatic run_scan(input bit scramble, input bit poke, output int done_cyc,
                            output int n_done, output int busy1, output int cnt_done);
        int n;
        @(negedge clk);
        start = 1'b1;
        done_cyc = -1; n_done = 0; busy1 = 0; cnt_done = -1; n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            start = poke && (n == 5);
            if (n == 1) busy1 = int'(busy);
            if (scramble) begin
                ly   = 8'($urandom);
                tall = 1'($urandom);
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = n;
                    cnt_done = int'(sel_count);
                end
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
        end
    endtask

    initial begin
        int dc, nd, b1, cd, n;
        reset = 1'b1; start = 1'b0; ly = 8'd0; tall = 1'b0;
        load_pattern(5);

        add(0, 0, 0, 2, 3, 7);
        add(1, 10, 0, 10, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9);
        add(2, 15, 0, 0);
        add(2, 15, 1, 1, 0);
        add(5, 7, 1, 0);
        add(2, 7, 0, 1, 0);
        add(2, 8, 0, 0);
`ifdef OAM_XSORT_EN
        add(3, 0, 0, 3, 5, 2, 9);
`else
        add(3, 0, 0, 3, 2, 5, 9);
`endif
        add(4, 240, 0, 1, 4);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.oam_idx", int'(oam_idx), 0);
        chk("rst.count", int'(sel_count), 0);
        chk("rst.list", int'(|{sel_idx, sel_x}), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            load_pattern(tbl[i].pat);
            ly   = 8'(tbl[i].lyv);
            tall = tbl[i].tallv;
            run_scan(1'b0, i == 0, dc, nd, b1, cd);
            chk($sformatf("v%0d.done_cycle", i), dc, 42);
            chk($sformatf("v%0d.done_pulses", i), nd, 1);
            chk($sformatf("v%0d.busy1", i), b1, 1);
            chk($sformatf("v%0d.hold_count", i), int'(sel_count), cd);
            exp_cnt = tbl[i].cnt;
            for (int s = 0; s < MP; s++) exp_idx[s] = tbl[i].idx[s];
            check_list($sformatf("v%0d", i));
        end

        for (int r = 0; r < 30; r++) begin
            int lyr;
            bit tr;
            lyr = int'($urandom_range(0, 255));
            tr  = 1'($urandom);
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 1) == 0) y_mem[k] = 8'(lyr + 16 - int'($urandom_range(0, 24)));
                else                           y_mem[k] = 8'($urandom);
                x_mem[k] = 8'($urandom_range(0, 7) * 16);
            end
            model(lyr, tr);
            ly = 8'(lyr); tall = tr;
            run_scan(1'b1, 1'b0, dc, nd, b1, cd);
            chk($sformatf("r%0d.done_cycle", r), dc, 42);
            check_list($sformatf("r%0d", r));
        end

        load_pattern(1);
        ly = 8'd10; tall = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.count", int'(sel_count), 0);
        chk("midrst.oam_idx", int'(oam_idx), 0);
        chk("midrst.list", int'(|{sel_idx, sel_x}), 0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("midrst.no_done", nd, 0);
        chk("midrst.idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
